// File: rtl/mem_arb_defs_pkg.sv
// mem_arb_defs: shared state and owner encodings for the memory arbiter
package mem_arb_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        IPORT = 2'd1,
        DPORT = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arbiter_arb_grant.sv
// arb_grant: data-priority grant with an instruction anti-starvation counter
module arb_grant
    import mem_arb_defs::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       i_req,
    input  logic       d_req,
    output logic [1:0] grant
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve;

    // data wins unless the instruction port has lost STARVE_LIMIT times in a row
    always_comb
        grant = !en ? NONE :
                (d_req && (starve < SW'(STARVE_LIMIT) || !i_req)) ? DPORT :
                i_req ? IPORT : NONE;

    // count consecutive lost arbitrations; only arbitration cycles update it
    always_ff @(posedge clk)
        if (rst)
            starve <= '0;
        else if (en)
            starve <= (!i_req || grant == IPORT) ? '0 :
                      (grant == DPORT && starve != SW'(STARVE_LIMIT)) ? starve + 1'b1 : starve;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between instruction and data ports
module mem_arbiter
    import mem_arb_defs::*;
#(
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_rdata,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    output logic        err
);

    localparam int CW = $clog2(LATENCY) + 1;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          wr_q;
    logic [1:0]    grant;
    logic          d_req, bad_d, bad_i, go_d, go_i, fin;

    assign d_req = d_rd | d_wr;
    assign bad_d = d_addr[0] | (d_rd & d_wr);
    assign bad_i = i_addr[0];
    assign go_d  = grant == DPORT;
    assign go_i  = grant == IPORT;
    assign fin   = cnt == '0;

    arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
        .clk   (clk),
        .rst   (rst),
        .en    (state == IDLE),
        .i_req (i_req),
        .d_req (d_req),
        .grant (grant)
    );

    // state, latency counter and write flag; the counter reloads every idle cycle
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state == IDLE) ? CW'(LATENCY - 1) : (fin ? cnt : cnt - 1'b1);
            wr_q  <= (state == IDLE) ? d_wr : wr_q;
        end

    // aligned grants enter BUSY; busy states leave once the counter reaches zero
    always_comb
        state_n = (state == IDLE) ? ((go_d && !bad_d) ? BUSY_D :
                                     (go_i && !bad_i) ? BUSY_I : IDLE) :
                  fin ? IDLE : state;

    // command strobe on aligned grants, zero-latency error completion, data return at count zero
    always_comb begin
        mem_en    = (go_d && !bad_d) || (go_i && !bad_i);
        mem_wr    = go_d && !bad_d && d_wr;
        mem_addr  = (go_d && !bad_d) ? d_addr : (go_i && !bad_i) ? i_addr : '0;
        mem_wdata = ((go_d && !bad_d) || (go_i && !bad_i)) ? d_wdata : '0;
        err       = (go_d && bad_d) || (go_i && bad_i);
        d_done    = (go_d && bad_d) || (state == BUSY_D && fin);
        i_done    = (go_i && bad_i) || (state == BUSY_I && fin);
        d_rdata   = (state == BUSY_D && fin && !wr_q) ? mem_rdata : '0;
        i_rdata   = (state == BUSY_I && fin) ? mem_rdata : '0;
    end

    assign i_stall = i_req & ~i_done;
    assign d_stall = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a two-stage memory model
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int SL  = 3;

    logic        clk = 0, rst = 1;
    logic        i_req = 0, d_rd = 0, d_wr = 0;
    logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr, err;

    int cyc = 0, total = 0, bad = 0;

    typedef struct {
        bit          dport;
        bit          e;
        logic [15:0] rdata;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    logic [15:0] m_rd;

    logic [15:0] mem [0:511];
    logic [15:0] p0, p1;
    logic        bd_we = 0;
    logic [8:0]  bd_idx = 0;
    logic [15:0] bd_val = 0;

    mem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .i_stall   (i_stall),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .d_stall   (d_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory: read data appears LAT cycles after mem_en, pipeline cleared by rst
    assign mem_rdata = p1;
    always @(posedge clk) begin
        if (rst) begin
            p0 <= 0;
            p1 <= 0;
        end else begin
            p1 <= p0;
            p0 <= (mem_en && !mem_wr) ? mem[mem_addr[9:1]] : 16'h0;
            if (mem_en && mem_wr) mem[mem_addr[9:1]] <= mem_wdata;
        end
        if (bd_we) mem[bd_idx] <= bd_val;
    end

    // scoreboard: every completion pops the oldest expectation
    always @(negedge clk) begin
        #2;
        if (!rst && (i_done || d_done)) begin
            total++;
            m_rd = d_done ? d_rdata : i_rdata;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: cycle %0d i_done=%0b d_done=%0b, required no completion", cyc, i_done, d_done);
            end else begin
                m_e = sb.pop_front();
                if ({d_done, i_done, err, m_rd} !== {m_e.dport, !m_e.dport, m_e.e, m_e.rdata} || cyc != m_e.at) begin
                    bad++;
                    $display("FAIL completion: got d_done=%0b i_done=%0b err=%0b rdata=%h cycle=%0d, required dport=%0b err=%0b rdata=%h cycle=%0d",
                             d_done, i_done, err, m_rd, cyc, m_e.dport, m_e.e, m_e.rdata, m_e.at);
                end
            end
        end
    end

    task automatic idle(input int n);
        i_req = 0; d_rd = 0; d_wr = 0; d_wdata = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        bd_we = 1; bd_idx = a[9:1]; bd_val = v;
        @(negedge clk);
        bd_we = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        total++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, err, i_rdata, d_rdata, i_stall, d_stall} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: mem_en=%0b mem_addr=%h i_done=%0b d_done=%0b err=%0b stalls=%0b%0b, required all 0",
                     mem_en, mem_addr, i_done, d_done, err, i_stall, d_stall);
        end
        @(negedge clk);
    endtask

    task automatic test_data_read;
        int t;
        preload(16'h0010, 16'hBEEF);
        d_rd = 1; d_addr = 16'h0010; t = cyc;
        sb.push_back('{1'b1, 1'b0, 16'hBEEF, t + LAT});
        #1;
        total++;
        if ({mem_en, mem_wr, mem_addr, d_stall} !== {1'b1, 1'b0, 16'h0010, 1'b1}) begin
            bad++;
            $display("FAIL read_issue: mem_en=%0b mem_wr=%0b mem_addr=%h d_stall=%0b, required 1 0 0010 1", mem_en, mem_wr, mem_addr, d_stall);
        end
        @(negedge clk); #1;
        total++;
        if ({mem_en, d_stall, d_done} !== 3'b010) begin
            bad++;
            $display("FAIL read_wait: mem_en=%0b d_stall=%0b d_done=%0b, required 0 1 0", mem_en, d_stall, d_done);
        end
        @(negedge clk); #3;
        total++;
        if (d_stall !== 1'b0) begin
            bad++;
            $display("FAIL read_stall_drop: d_stall=%0b, required 0", d_stall);
        end
        d_rd = 0;
        idle(2);
    endtask

    task automatic test_priority;
        int t;
        logic        xe;
        logic [15:0] xa;
        preload(16'h0100, 16'h1111);
        preload(16'h0012, 16'h2222);
        i_req = 1; i_addr = 16'h0100; d_rd = 1; d_addr = 16'h0012; t = cyc;
        sb.push_back('{1'b1, 1'b0, 16'h2222, t + LAT});
        sb.push_back('{1'b0, 1'b0, 16'h1111, t + 2 * LAT + 1});
        for (int k = 0; k < 6; k++) begin
            #1;
            xe = (k == 0 || k == 3);
            xa = k == 0 ? 16'h0012 : k == 3 ? 16'h0100 : 16'h0;
            total++;
            if ({mem_en, mem_addr} !== {xe, xa}) begin
                bad++;
                $display("FAIL priority_cmd k=%0d: mem_en=%0b mem_addr=%h, required %0b %h", k, mem_en, mem_addr, xe, xa);
            end
            #2;
            if (d_done) d_rd = 0;
            if (i_done) i_req = 0;
            @(negedge clk);
        end
        idle(2);
    endtask

    task automatic test_starve;
        int t;
        logic        xe;
        logic [15:0] xa;
        preload(16'h0020, 16'hA5A5);
        preload(16'h0200, 16'h5A5A);
        i_req = 1; i_addr = 16'h0200; d_rd = 1; d_addr = 16'h0020; t = cyc;
        for (int g = 0; g < 5; g++)
            sb.push_back(g == 3 ? '{1'b0, 1'b0, 16'h5A5A, t + 3 * g + LAT} : '{1'b1, 1'b0, 16'hA5A5, t + 3 * g + LAT});
        for (int k = 0; k < 15; k++) begin
            #1;
            xe = (k % 3 == 0);
            xa = !xe ? 16'h0 : k == 9 ? 16'h0200 : 16'h0020;
            total++;
            if ({mem_en, mem_addr} !== {xe, xa}) begin
                bad++;
                $display("FAIL starve_cmd k=%0d: mem_en=%0b mem_addr=%h, required %0b %h", k, mem_en, mem_addr, xe, xa);
            end
            #2;
            if (i_done) i_req = 0;
            if (k == 14) d_rd = 0;
            @(negedge clk);
        end
        idle(2);
    endtask

    task automatic test_err;
        d_wr = 1; d_addr = 16'h0021; d_wdata = 16'hFFFF;
        sb.push_back('{1'b1, 1'b1, 16'h0, cyc});
        #1;
        total++;
        if ({mem_en, err, d_done, d_stall} !== 4'b0110) begin
            bad++;
            $display("FAIL err_dmis: mem_en=%0b err=%0b d_done=%0b d_stall=%0b, required 0 1 1 0", mem_en, err, d_done, d_stall);
        end
        #2; d_wr = 0;
        @(negedge clk);
        i_req = 1; i_addr = 16'h0101;
        sb.push_back('{1'b0, 1'b1, 16'h0, cyc});
        #1;
        total++;
        if ({mem_en, err, i_done, i_stall} !== 4'b0110) begin
            bad++;
            $display("FAIL err_imis: mem_en=%0b err=%0b i_done=%0b i_stall=%0b, required 0 1 1 0", mem_en, err, i_done, i_stall);
        end
        #2; i_req = 0;
        @(negedge clk);
        d_rd = 1; d_wr = 1; d_addr = 16'h0030;
        sb.push_back('{1'b1, 1'b1, 16'h0, cyc});
        #1;
        total++;
        if ({mem_en, err, d_done} !== 3'b011) begin
            bad++;
            $display("FAIL err_rdwr: mem_en=%0b err=%0b d_done=%0b, required 0 1 1", mem_en, err, d_done);
        end
        #2; d_rd = 0; d_wr = 0;
        @(negedge clk);
        d_rd = 1; d_addr = 16'h0010;
        sb.push_back('{1'b1, 1'b0, 16'hBEEF, cyc + LAT});
        #1;
        total++;
        if ({mem_en, err, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
            bad++;
            $display("FAIL err_then_idle: mem_en=%0b err=%0b mem_addr=%h, required 1 0 0010", mem_en, err, mem_addr);
        end
        @(negedge clk);
        @(negedge clk); #3;
        d_rd = 0;
        idle(2);
    endtask

    task automatic test_rst_busy;
        preload(16'h0102, 16'h3333);
        i_req = 1; i_addr = 16'h0100;
        #1;
        total++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0100}) begin
            bad++;
            $display("FAIL rst_issue: mem_en=%0b mem_addr=%h, required 1 0100", mem_en, mem_addr);
        end
        @(negedge clk);
        rst = 1; i_req = 0;
        @(negedge clk);
        rst = 0;
        #1;
        total++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, err, i_rdata, d_rdata} !== '0) begin
            bad++;
            $display("FAIL rst_abandon: mem_en=%0b i_done=%0b d_done=%0b err=%0b i_rdata=%h, required all 0", mem_en, i_done, d_done, err, i_rdata);
        end
        i_req = 1; i_addr = 16'h0102;
        sb.push_back('{1'b0, 1'b0, 16'h3333, cyc + LAT});
        #1;
        total++;
        if ({mem_en, mem_addr} !== {1'b1, 16'h0102}) begin
            bad++;
            $display("FAIL rst_fresh: mem_en=%0b mem_addr=%h, required 1 0102", mem_en, mem_addr);
        end
        @(negedge clk);
        @(negedge clk); #3;
        i_req = 0;
        idle(2);
    endtask

    task automatic test_back_to_back;
        int t;
        logic [33:0] xc;
        d_wr = 1; d_addr = 16'h0040; d_wdata = 16'h1234; t = cyc;
        sb.push_back('{1'b1, 1'b0, 16'h0, t + LAT});
        sb.push_back('{1'b1, 1'b0, 16'h1234, t + 2 * LAT + 1});
        for (int k = 0; k < 6; k++) begin
            #1;
            xc = k == 0 ? {1'b1, 1'b1, 16'h0040, 16'h1234} :
                 k == 3 ? {1'b1, 1'b0, 16'h0040, 16'h0000} : '0;
            total++;
            if ({mem_en, mem_wr, mem_addr, mem_wdata} !== xc) begin
                bad++;
                $display("FAIL wr_rd_cmd k=%0d: en=%0b wr=%0b addr=%h wdata=%h, required %h", k, mem_en, mem_wr, mem_addr, mem_wdata, xc);
            end
            #2;
            if (k == 2) begin d_wr = 0; d_rd = 1; d_wdata = 0; end
            if (k == 5) d_rd = 0;
            @(negedge clk);
        end
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_data_read;
        test_priority;
        test_starve;
        test_err;
        test_rst_busy;
        test_back_to_back;
        idle(3);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL pending_completions: %0d outstanding, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported, fixed-latency data memory between the fetch stage (read-only instruction port) and the memory stage (read/write data port). Sits between both pipeline stages and the memory macro. Arbitrates with data-port priority plus an instruction anti-starvation limit, sequences one access at a time, and returns per-port done/stall handshakes. Misaligned accesses are rejected with an error pulse.

## Interface
- LATENCY, 2: cycles from command issue to read data/done; legal range ≥1.
- STARVE_LIMIT, 3: consecutive lost arbitrations after which the instruction port wins the next arbitration; ≥1.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- i_req  in  1  instruction read request; held with i_addr until i_done.
- i_addr  in  16  instruction byte address.
- i_rdata  out  16  instruction word; valid only while i_done=1.
- i_done  out  1  one-cycle completion pulse, instruction port.
- i_stall  out  1  i_req & ~i_done.
- d_rd, d_wr  in  1 each  data read or write request; mutually exclusive; held with d_addr/d_wdata until d_done.
- d_addr  in  16  data byte address.
- d_wdata  in  16  write data.
- d_rdata  out  16  read data; valid only while d_done=1 after a read.
- d_done  out  1  one-cycle completion pulse, data port.
- d_stall  out  1  (d_rd|d_wr) & ~d_done.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_en  out  1  one-cycle command strobe.
- mem_wr  out  1  write qualifier, valid with mem_en.
- mem_rdata  in  16  memory read data, valid LATENCY cycles after mem_en.
- err  out  1  one-cycle pulse: misaligned request or simultaneous d_rd&d_wr.

## Operation
- States: IDLE, BUSY_I, BUSY_D. Reset → IDLE, latency counter 0, starve counter 0, owner none.
- IDLE: evaluate requests combinationally in the same cycle.
  - Data pending and starve count < STARVE_LIMIT → grant data. Otherwise, instruction pending → grant instruction. Data alone → data; instruction alone → instruction.
  - Granted request with addr[0]=1 (or d_rd&d_wr): no memory command. err=1 and the port's done=1 this cycle, rdata=0. Stay IDLE. Starve counter updates as for a normal grant.
  - Aligned grant: mem_en=1 with mem_addr, mem_wr=d_wr for data grants and 0 for instruction grants, mem_wdata=d_wdata. Load counter to LATENCY-1, go to BUSY_I/BUSY_D. If LATENCY=1, complete in the next cycle.
- BUSY_x: decrement counter each cycle. At 0, assert x_done and pass mem_rdata to x_rdata, then return to IDLE on the next edge. A write also completes at LATENCY; d_rdata=0 for writes.
- No requests are evaluated while BUSY; a new grant can issue in the cycle after done, so throughput is one access per LATENCY+1 cycles.
- Starve counter: increments when the instruction port is pending and data is granted; clears on any instruction grant or when i_req is low in IDLE; saturates at STARVE_LIMIT.
- Idle outputs: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, both done=0, both rdata=0, err=0.
- Requests dropped while BUSY (protocol violation) are not checked; the access completes normally.

## Timing
- Reset values: every output 0. Stall outputs follow the request inputs combinationally, so they are 0 while requests are low.
- Request raised at cycle t with the arbiter IDLE: mem_en at t, done at t+LATENCY, next possible mem_en at t+LATENCY+1.
- Error path: done and err at cycle t, zero latency, no mem_en.
- rst during BUSY: return to IDLE on that edge and abandon the outstanding access, with no done. The memory is assumed reset by the same rst.
- Requests arriving at the same edge as done are not granted until the following IDLE cycle.

## Structure
- Shared package/include mem_arb_defs: state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2) and owner encoding (NONE, IPORT, DPORT).
- One sub-module: arb_grant, combinational priority-plus-starvation grant logic with the registered starve counter. The FSM and latency counter stay in mem_arbiter.

## Test plan
- Data read, LATENCY=2, d_addr=0x0010, mem returns 0xBEEF → mem_en at t, d_done and d_rdata=0xBEEF at t+2, d_stall high at t and t+1.
- Simultaneous i_req and d_rd at t → data granted at t, instruction mem_en at t+3, i_done at t+5.
- Data requests back-to-back with i_req held, STARVE_LIMIT=3 → three data grants, then instruction wins the fourth arbitration.
- d_wr with d_addr=0x0021 → err=1 and d_done=1 in the same cycle, mem_en never asserted, state stays IDLE.
- rst asserted at t+1 of an instruction read → no i_done, all outputs 0 at t+2, and a fresh request at t+2 issues mem_en at t+2.
- Write 0x1234 to 0x0040, then read 0x0040 → write d_done at LATENCY, read returns 0x1234, with two accesses spaced LATENCY+1 apart.
